// File: rtl/core_dbg_pkg.sv
// Shared debug/run-control types for the RV32 core.
// State and halt-cause encodings used by the run controller.
package core_dbg_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    STEP   = 2'd3
  } run_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_REQ  = 2'd1,
    CAUSE_BP   = 2'd2,
    CAUSE_STEP = 2'd3
  } halt_cause_t;

endpackage

// File: rtl/wrap_counter.sv
// Free-running enable-gated counter.
// Wraps modulo 2^WIDTH, async active-low clear.
module wrap_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc)
      count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/halt/step controller: gates PC advance and commit,
// handles breakpoints, single-step and perf counters.
module core_run_ctrl
  import core_dbg_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            halt_req,
  input  logic            resume_req,
  input  logic            step_req,
  input  logic            bp_en,
  input  logic [XLEN-1:0] bp_addr,
  input  logic [XLEN-1:0] pc,
  output logic            pc_en,
  output logic            commit_en,
  output logic            halted,
  output logic [1:0]      halt_cause,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret_cnt
);

  localparam int HW =
    (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

  run_state_t  state_q, state_d;
  halt_cause_t cause_q, cause_d;
  logic [HW-1:0] hold_q, hold_d;
  logic skip_q, skip_d;
  logic bp_hit;
  logic run_ok;

  assign bp_hit = bp_en & (pc == bp_addr) & ~skip_q;
  assign run_ok = ~halt_req & ~bp_hit;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    hold_d  = hold_q;
    pc_en   = 1'b0;
    unique case (state_q)
      HOLD: begin
        hold_d = hold_q + HW'(1);
        if (hold_q == HOLD_LAST) begin
          if (halt_req) begin
            state_d = HALTED;
            cause_d = CAUSE_REQ;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        pc_en = run_ok;
        if (halt_req) begin
          state_d = HALTED;
          cause_d = CAUSE_REQ;
        end else if (bp_hit) begin
          state_d = HALTED;
          cause_d = CAUSE_BP;
        end
      end
      HALTED: begin
        if (resume_req)
          state_d = RUN;
        else if (step_req)
          state_d = STEP;
      end
      STEP: begin
        pc_en   = 1'b1;
        state_d = HALTED;
        cause_d = CAUSE_STEP;
      end
      default: state_d = HOLD;
    endcase
  end

  // Skip lets a resumed breakpoint instruction execute once.
  always_comb begin
    skip_d = skip_q;
    if (pc_en)
      skip_d = 1'b0;
    else if (state_q == HALTED && (resume_req || step_req))
      skip_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HOLD;
      cause_q <= CAUSE_NONE;
      hold_q  <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      hold_q  <= hold_d;
      skip_q  <= skip_d;
    end
  end

  assign commit_en  = pc_en;
  assign halted     = (state_q == HALTED);
  assign halt_cause = cause_q;

  wrap_counter #(.WIDTH(XLEN)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (state_q != HOLD),
    .count (cycle_cnt)
  );

  wrap_counter #(.WIDTH(XLEN)) u_instret_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (commit_en),
    .count (instret_cnt)
  );

endmodule
